// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and default parameter values for button_enable_gen.
//   btn_state_t : debounce FSM state encoding
//   DEF_*       : default values for the button_enable_gen parameters
// -----------------------------------------------------------------------------
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
   localparam int unsigned DEF_PRESCALE        = 10;
   localparam int unsigned DEF_REPEAT_DELAY    = 16;
   localparam int unsigned DEF_REPEAT_PERIOD   = 8;

endpackage

// File: rtl/button_enable_gen_if.sv
// -----------------------------------------------------------------------------
// button_enable_gen_if
// Groups the button-side inputs and counter-side outputs of button_enable_gen.
//   btn_raw   : raw push-button, asynchronous, active-high, may bounce
//   free_run  : 1 = periodic tick mode
//   enable    : single-cycle pulse to the counter
//   btn_level : debounced button level
// Modports: master drives the inputs and observes the outputs; slave is the
// generator itself.
// -----------------------------------------------------------------------------
interface button_enable_gen_if;

   logic btn_raw;
   logic free_run;
   logic enable;
   logic btn_level;

   modport master (
      output btn_raw,
      output free_run,
      input  enable,
      input  btn_level
   );

   modport slave (
      input  btn_raw,
      input  free_run,
      output enable,
      output btn_level
   );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops cleared to 0
//   d_i   : asynchronous input
//   q_o   : synchronized output, lags d_i by two rising edges
// -----------------------------------------------------------------------------
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/button_enable_gen.sv
// -----------------------------------------------------------------------------
// button_enable_gen
// Generates the up-counter's enable: one single-cycle pulse per debounced
// press of a bouncy push-button, optionally OR-ed with a free-running tick.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : button_enable_gen_if.slave (btn_raw, free_run in; enable,
//           btn_level out)
// Optional feature: define BTN_AUTOREPEAT_EN to emit auto-repeat pulses while
// the button stays held (first after REPEAT_DELAY cycles in HELD, then every
// REPEAT_PERIOD cycles). Without it, HELD emits no further pulses.
// -----------------------------------------------------------------------------
module button_enable_gen
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned PRESCALE        = DEF_PRESCALE,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic                clk,
   input  logic                reset,
   button_enable_gen_if.slave  bus
);

   localparam int unsigned     DCW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned     PCW       = $clog2(PRESCALE);
   localparam logic [DCW-1:0]  DCNT_LAST = DCW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PCW-1:0]  PCNT_LAST = PCW'(PRESCALE - 1);

   // Elaboration-time legality checks on the parameters.
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES out of range 1..255");
   end
   if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
      $error("PRESCALE out of range 2..65535");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
   end

   logic            btn_sync;
   btn_state_t      state_q;
   logic [DCW-1:0]  dcnt_q;
   logic [PCW-1:0]  pcnt_q;
   logic            level_q;
   logic            enable_q;
   logic            press_d;
   logic            tick_d;
   logic            rep_d;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (bus.btn_raw),
      .q_o   (btn_sync)
   );

   // Event strobes for the current edge; enable_q registers their OR so
   // coincident events collapse into a single pulse.
   always_comb begin
      press_d = (state_q == PRESS_WAIT) && btn_sync && (dcnt_q == DCNT_LAST);
      tick_d  = bus.free_run && (pcnt_q == PCNT_LAST);
   end

   // Prescaler: held at 0 while free_run is low, so the first tick lands
   // PRESCALE edges after free_run is first sampled high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt_q <= '0;
      end else if (!bus.free_run || pcnt_q == PCNT_LAST) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_q + PCW'(1);
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RCW  = $clog2(RMAX + 1);

   logic [RCW-1:0] rcnt_q;
   logic           rphase_q;
   logic [RCW-1:0] rlast;

   // rphase_q selects between the initial delay and the repeat period once
   // the first repeat pulse has fired. Both are cleared whenever HELD is
   // left, so a HELD->RELEASE_WAIT->HELD bounce restarts the delay.
   always_comb begin
      rlast = rphase_q ? RCW'(REPEAT_PERIOD - 1) : RCW'(REPEAT_DELAY - 1);
      rep_d = (state_q == HELD) && btn_sync && (rcnt_q == rlast);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rcnt_q   <= '0;
         rphase_q <= 1'b0;
      end else if (state_q != HELD || !btn_sync) begin
         rcnt_q   <= '0;
         rphase_q <= 1'b0;
      end else if (rcnt_q == rlast) begin
         rcnt_q   <= '0;
         rphase_q <= 1'b1;
      end else begin
         rcnt_q   <= rcnt_q + RCW'(1);
      end
   end
`else
   always_comb begin
      rep_d = 1'b0;
   end
`endif

   // Debounce FSM with registered level and enable outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         dcnt_q   <= '0;
         level_q  <= 1'b0;
         enable_q <= 1'b0;
      end else begin
         enable_q <= press_d | tick_d | rep_d;
         case (state_q)
            IDLE: begin
               if (btn_sync) begin
                  state_q <= PRESS_WAIT;
                  dcnt_q  <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_sync) begin
                  state_q <= IDLE;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_q <= HELD;
                  level_q <= 1'b1;
               end else begin
                  dcnt_q  <= dcnt_q + DCW'(1);
               end
            end
            HELD: begin
               if (!btn_sync) begin
                  state_q <= RELEASE_WAIT;
                  dcnt_q  <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (btn_sync) begin
                  state_q <= HELD;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_q <= IDLE;
                  level_q <= 1'b0;
               end else begin
                  dcnt_q  <= dcnt_q + DCW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.enable    = enable_q;
   assign bus.btn_level = level_q;

endmodule
